// File: rtl/eth_tx_frame_fifo.sv
// Store-and-forward TX frame buffer between the encapsulation engine and the 10G MAC.
// A frame is released only after its last beat is stored; bad or oversize frames are dropped and counted.
module eth_tx_frame_fifo #(
  parameter int ADDR_W = 9
) (
  input  logic        clk156,
  input  logic        eth_rst,
  input  logic        s_axis_tx_tvalid,
  output logic        s_axis_tx_tready,
  input  logic [63:0] s_axis_tx_tdata,
  input  logic [7:0]  s_axis_tx_tkeep,
  input  logic        s_axis_tx_tlast,
  input  logic        s_axis_tx_tuser,
  output logic        m_axis_tx_tvalid,
  input  logic        m_axis_tx_tready,
  output logic [63:0] m_axis_tx_tdata,
  output logic [7:0]  m_axis_tx_tkeep,
  output logic        m_axis_tx_tlast,
  output logic        m_axis_tx_tuser,
  output logic [15:0] drop_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int PW    = ADDR_W + 1;

  typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_DROP} wr_state_t;

  // Reset asserts immediately but releases two clk156 edges after eth_rst falls.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clk156 or posedge eth_rst) begin
    if (eth_rst) rst_sync_q <= 2'b11;
    else         rst_sync_q <= {rst_sync_q[0], 1'b0};
  end

  assign rst_int = rst_sync_q[1];

  wr_state_t   state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] drop_q, drop_d;
  logic        r_valid_q, r_valid_d;
  logic        m_valid_q, m_valid_d;
  logic [72:0] m_beat_q, m_beat_d;
  logic [72:0] rd_data_q;
  logic [72:0] mem [DEPTH];

  logic [PW-1:0] used;
  logic        full;
  logic        s_ready;
  logic        s_acc;
  logic        wr_en;
  logic        avail;
  logic        o_load;
  logic        rd_en;
  logic [15:0] drop_inc;

  assign used     = wr_ptr_q - rd_ptr_q;
  assign full     = (used == PW'(DEPTH));
  assign s_acc    = s_axis_tx_tvalid && s_ready;
  assign drop_inc = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    drop_d      = drop_q;
    s_ready     = 1'b0;
    wr_en       = 1'b0;
    case (state_q)
      WR_IDLE, WR_DATA: begin
        if (full && (state_q == WR_DATA) && (wr_commit_q == rd_ptr_q)) begin
          // The frame in progress alone fills the buffer: it can never be sent, so discard it.
          s_ready  = 1'b1;
          wr_ptr_d = wr_commit_q;
          state_d  = WR_DROP;
          if (s_acc && s_axis_tx_tlast) begin
            drop_d  = drop_inc;
            state_d = WR_IDLE;
          end
        end else if (!full) begin
          s_ready = 1'b1;
          if (s_acc) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_axis_tx_tlast) begin
              state_d = WR_IDLE;
              if (s_axis_tx_tuser) begin
                wr_ptr_d = wr_commit_q;
                drop_d   = drop_inc;
              end else begin
                wr_commit_d = wr_ptr_q + PW'(1);
              end
            end else begin
              state_d = WR_DATA;
            end
          end
        end
      end
      WR_DROP: begin
        s_ready = 1'b1;
        if (s_acc && s_axis_tx_tlast) begin
          drop_d  = drop_inc;
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Two-deep read pipeline: RAM read register feeding the output register, refilled whenever a slot frees.
  always_comb begin
    avail     = (rd_ptr_q != wr_commit_q);
    o_load    = r_valid_q && (!m_valid_q || m_axis_tx_tready);
    rd_en     = avail && (!r_valid_q || o_load);
    r_valid_d = rd_en || (r_valid_q && !o_load);
    rd_ptr_d  = rd_ptr_q + PW'(rd_en);
    m_valid_d = m_valid_q;
    m_beat_d  = m_beat_q;
    if (o_load) begin
      m_valid_d = 1'b1;
      m_beat_d  = rd_data_q;
    end else if (m_axis_tx_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk156) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata};
    if (rd_en) rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
  end

  always_ff @(posedge clk156 or posedge rst_int) begin
    if (rst_int) begin
      state_q     <= WR_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      drop_q      <= '0;
      r_valid_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      m_beat_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      drop_q      <= drop_d;
      r_valid_q   <= r_valid_d;
      m_valid_q   <= m_valid_d;
      m_beat_q    <= m_beat_d;
    end
  end

  assign s_axis_tx_tready = s_ready && !rst_int;
  assign m_axis_tx_tvalid = m_valid_q;
  assign m_axis_tx_tlast  = m_beat_q[72];
  assign m_axis_tx_tkeep  = m_beat_q[71:64];
  assign m_axis_tx_tdata  = m_beat_q[63:0];
  assign m_axis_tx_tuser  = 1'b0;
  assign drop_count       = drop_q;

endmodule
